// File: rtl/prng_stream_pkg.sv
// Shared types for the PRNG stream buffer: FSM state encoding and the generator word type.
package prng_stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} stream_state_e;

  localparam int WORD_W = 64;
  typedef logic [WORD_W-1:0] prng_word_t;
endpackage

// File: rtl/prng_word_fifo.sv
// Synchronous word FIFO; power-of-two depth so pointers wrap naturally, full/empty derived from level.
module prng_word_fifo
  import prng_stream_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  prng_word_t                 wr_data_i,
  input  logic                       pop_i,
  output prng_word_t                 rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  prng_word_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by level_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/prng_stream_buffer.sv
// Throttles q_analog_prng, buffers its words and serialises them MSB-first onto a valid/ready stream.
// Optional repetition-count health test is compiled in with `define PRNG_HEALTH_EN.
module prng_stream_buffer
  import prng_stream_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int OUT_W     = 8,
  parameter int HT_CUTOFF = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  output logic                       gen_en,
  input  prng_word_t                 prng_word,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [31:0]                word_cnt,
  output logic                       ht_fail
);
  localparam int NCHUNK = WORD_W / OUT_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  if ((WORD_W % OUT_W) != 0) begin : g_chk_out_w
    $error("OUT_W must divide WORD_W");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (HT_CUTOFF < 2) begin : g_chk_cutoff
    $error("HT_CUTOFF must be >= 2");
  end

  stream_state_e    state_q, state_d;
  logic             gen_q;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  prng_word_t       fifo_rd;
  logic [LVL_W-1:0] level;
  prng_word_t       sreg_q, sreg_d;
  logic             ser_vld_q, ser_vld_d;
  logic [CNT_W-1:0] chunk_q, chunk_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic             hs, last_chunk, start_acc, ht_fail_d;

  prng_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (fifo_push),
    .wr_data_i (prng_word),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // The word requested last cycle is on prng_word now; the throttle guarantees room for it.
  assign fifo_push = gen_q && !fifo_full;
  assign start_acc = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (stop || ht_fail_d) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !ser_vld_q && !gen_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    gen_en = (state_q == ST_RUN) && ((int'(level) + int'(gen_q)) < DEPTH);
  end

  // Serialiser: reload straight after the final chunk so back-to-back words have no bubble.
  assign hs         = ser_vld_q && out_ready;
  assign last_chunk = (chunk_q == CNT_W'(NCHUNK - 1));
  assign fifo_pop   = (!ser_vld_q || (hs && last_chunk)) && !fifo_empty;

  always_comb begin
    sreg_d    = sreg_q;
    chunk_d   = chunk_q;
    ser_vld_d = ser_vld_q;
    if (fifo_pop) begin
      sreg_d    = fifo_rd;
      chunk_d   = '0;
      ser_vld_d = 1'b1;
    end else if (hs) begin
      sreg_d  = sreg_q << OUT_W;
      chunk_d = chunk_q + CNT_W'(1);
      if (last_chunk) ser_vld_d = 1'b0;
    end
    word_cnt_d = word_cnt_q;
    if (start_acc)      word_cnt_d = '0;
    else if (fifo_push) word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q      <= 1'b0;
      sreg_q     <= '0;
      ser_vld_q  <= 1'b0;
      chunk_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      gen_q      <= gen_en;
      sreg_q     <= sreg_d;
      ser_vld_q  <= ser_vld_d;
      chunk_q    <= chunk_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_data   = sreg_q[WORD_W-1 -: OUT_W];
  assign out_valid  = ser_vld_q;
  assign fifo_level = level;
  assign word_cnt   = word_cnt_q;

`ifdef PRNG_HEALTH_EN
  localparam int REP_W = $clog2(HT_CUTOFF + 1);

  prng_word_t       last_q;
  logic             have_q;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             ht_q, ht_trip;

  // rep_cnt saturates at the cutoff so a long run cannot wrap back below it.
  always_comb begin
    rep_d = rep_q;
    if (fifo_push) begin
      if (have_q && (prng_word == last_q)) begin
        if (rep_q != REP_W'(HT_CUTOFF)) rep_d = rep_q + REP_W'(1);
      end else begin
        rep_d = REP_W'(1);
      end
    end
  end

  assign ht_trip   = fifo_push && (rep_d == REP_W'(HT_CUTOFF));
  assign ht_fail_d = ht_q || ht_trip;
  assign ht_fail   = ht_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_q <= 1'b0;
      rep_q  <= '0;
      ht_q   <= 1'b0;
    end else begin
      ht_q <= ht_fail_d;
      if (start_acc) begin
        have_q <= 1'b0;
        rep_q  <= '0;
      end else if (fifo_push) begin
        have_q <= 1'b1;
        rep_q  <= rep_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) last_q <= prng_word;
  end
`else
  assign ht_fail_d = 1'b0;
  assign ht_fail   = 1'b0;
`endif
endmodule

// File: tb/tb_prng_stream_buffer.sv
// Bench for prng_stream_buffer: random generator stub, word scoreboard and per-scenario tasks.
module tb_prng_stream_buffer;
  import prng_stream_pkg::*;

  localparam int DEPTH     = 8;
  localparam int OUT_W     = 8;
  localparam int HT_CUTOFF = 3;
  localparam int NCH       = WORD_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             gen_en;
  prng_word_t       prng_word = '0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic [3:0]       fifo_level;
  logic [31:0]      word_cnt;
  logic             ht_fail;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         ready_rand = 1'b0;
  bit         stub_const = 1'b0;
  prng_word_t gen_w;
  prng_word_t exp_q[$];
  prng_word_t obs_q[$];
  prng_word_t acc = '0;
  int         idx = 0;

  prng_stream_buffer #(.DEPTH(DEPTH), .OUT_W(OUT_W), .HT_CUTOFF(HT_CUTOFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .gen_en     (gen_en),
    .prng_word  (prng_word),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .fifo_level (fifo_level),
    .word_cnt   (word_cnt),
    .ht_fail    (ht_fail)
  );

  always #5 clk = ~clk;

  // Generator stub: a word requested on this edge appears on prng_word for the next cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (gen_en) begin
      gen_w = stub_const ? 64'hDEADBEEF_00000001 : {$urandom, $urandom};
      prng_word <= gen_w;
      exp_q.push_back(gen_w);
    end
  end

  always @(posedge clk) begin
    if (ready_rand) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Reassemble accepted chunks into words, first chunk = most significant.
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
    end else if (out_valid && out_ready) begin
      acc = {acc[WORD_W-OUT_W-1:0], out_data};
      idx = idx + 1;
      if (idx == NCH) begin
        obs_q.push_back(acc);
        idx = 0;
      end
    end
  end

  task automatic pulse(input logic s, input logic t);
    @(posedge clk); #1;
    start = s;
    stop  = t;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (gen_en !== 1'b0)     begin errors++; $display("FAIL reset gen_en: got %b expected 0", gen_en); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (ht_fail !== 1'b0)    begin errors++; $display("FAIL reset ht_fail: got %b expected 0", ht_fail); end
    checks++; if (out_data !== '0)     begin errors++; $display("FAIL reset out_data: got %h expected 0", out_data); end
    checks++; if (fifo_level !== '0)   begin errors++; $display("FAIL reset fifo_level: got %0d expected 0", fifo_level); end
    checks++; if (word_cnt !== 32'd0)  begin errors++; $display("FAIL reset word_cnt: got %0d expected 0", word_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || gen_en !== 1'b0) begin
      errors++; $display("FAIL reset idle_after_release: busy=%b gen_en=%b expected 0/0", busy, gen_en);
    end
  endtask

  task automatic test_free_run();
    int n_hs = 0;
    int bubbles = 0;
    bit seen = 1'b0;
    bit seen10 = 1'b0;
    bit ok;
    out_ready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 400 && n_hs < 10 * NCH; c++) begin
      @(negedge clk);
      if (!seen10 && word_cnt >= 32'd10) begin
        seen10 = 1'b1;
        checks++; if (word_cnt !== 32'd10) begin errors++; $display("FAIL free_run word_cnt: got %0d expected 10", word_cnt); end
      end
      if (seen && !out_valid) bubbles++;
      if (out_valid && out_ready) begin
        seen = 1'b1;
        n_hs++;
      end
    end
    checks++; if (n_hs != 10 * NCH) begin errors++; $display("FAIL free_run chunks: got %0d expected %0d", n_hs, 10 * NCH); end
    checks++; if (bubbles != 0)     begin errors++; $display("FAIL free_run bubbles: got %0d expected 0", bubbles); end
    pulse(1'b0, 1'b1);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL free_run drain_timeout: busy=%b expected 0", busy); end
    checks++; if (word_cnt !== 32'(exp_q.size())) begin
      errors++; $display("FAIL free_run word_cnt_total: got %0d expected %0d", word_cnt, exp_q.size());
    end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL free_run word_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL free_run word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    logic [OUT_W-1:0] held;
    bit ok;
    out_ready = 1'b0;
    pulse(1'b1, 1'b0);
    repeat (200) @(negedge clk);
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL bp fifo_level: got %0d expected 8", fifo_level); end
    checks++; if (gen_en !== 1'b0)     begin errors++; $display("FAIL bp gen_en: got %b expected 0", gen_en); end
    checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL bp out_valid: got %b expected 1", out_valid); end
    checks++; if (word_cnt !== 32'(DEPTH + 1)) begin errors++; $display("FAIL bp word_cnt: got %0d expected %0d", word_cnt, DEPTH + 1); end
    held = out_data;
    @(negedge clk);
    checks++; if (out_data !== held) begin errors++; $display("FAIL bp out_data_stable: got %h expected %h", out_data, held); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    pulse(1'b0, 1'b1);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp drain_timeout: busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp word_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stop_mid_word();
    int n_hs = 0;
    int last_hs = -1;
    int t_idle = 0;
    bit found = 1'b0;
    bit ok = 1'b0;
    out_ready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (n_hs == 2 * NCH + 3) begin
        found = 1'b1;
        break;
      end
      if (out_valid && out_ready) n_hs++;
    end
    checks++; if (!found) begin errors++; $display("FAIL stop_mid chunk3_timeout: got %0d chunks expected %0d", n_hs, 2 * NCH + 3); end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL stop_mid gen_en_after_stop: got %b expected 0", gen_en); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL stop_mid busy_draining: got %b expected 1", busy); end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        t_idle = cyc;
        break;
      end
      if (out_valid && out_ready) last_hs = cyc;
    end
    checks++; if (!ok) begin errors++; $display("FAIL stop_mid drain_timeout: busy=%b expected 0", busy); end
    // The final handshake completes on edge last_hs+1; busy drops on the following edge.
    checks++; if (t_idle != last_hs + 2) begin
      errors++; $display("FAIL stop_mid busy_fall: got cycle %0d expected %0d", t_idle, last_hs + 2);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stop_mid word_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stop_mid word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random_ready();
    bit reached = 1'b0;
    bit ok;
    ready_rand = 1'b1;
    pulse(1'b1, 1'b1);
    @(negedge clk);
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL rand start_stop_busy: got %b expected 1", busy); end
    checks++; if (gen_en !== 1'b1) begin errors++; $display("FAIL rand start_stop_run: gen_en got %b expected 1", gen_en); end
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (obs_q.size() >= 1000) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rand 1000_words_timeout: got %0d words expected 1000", obs_q.size()); end
    pulse(1'b0, 1'b1);
    wait_idle(2000, ok);
    ready_rand = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL rand drain_timeout: busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand word_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
    @(posedge clk); #2;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit ok;
    out_ready = 1'b0;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (fifo_level == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid level5_timeout: got %0d expected 5", fifo_level); end
    rst_n = 1'b0;
    #1;
    checks++; if ({gen_en, out_valid, busy, ht_fail} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid ctrl: got gen_en/valid/busy/ht=%b expected 0000", {gen_en, out_valid, busy, ht_fail});
    end
    checks++; if (out_data !== '0)    begin errors++; $display("FAIL rst_mid out_data: got %h expected 0", out_data); end
    checks++; if (fifo_level !== '0)  begin errors++; $display("FAIL rst_mid fifo_level: got %0d expected 0", fifo_level); end
    checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid word_cnt: got %0d expected 0", word_cnt); end
    exp_q.delete();
    obs_q.delete();
    idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    checks++; if (fifo_level !== '0 || word_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid restart: level=%0d word_cnt=%0d expected 0/0", fifo_level, word_cnt);
    end
    repeat (40) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid drain_timeout: busy=%b expected 0", busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_mid word_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

`ifdef PRNG_HEALTH_EN
  task automatic test_health();
    bit tripped = 1'b0;
    bit ok;
    stub_const = 1'b1;
    out_ready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ht_fail) begin
        tripped = 1'b1;
        break;
      end
    end
    checks++; if (!tripped) begin errors++; $display("FAIL health trip_timeout: ht_fail=%b expected 1", ht_fail); end
    checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL health trip_word: got %0d expected 3", word_cnt); end
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL health drain_timeout: busy=%b expected 0", busy); end
    checks++; if (ht_fail !== 1'b1) begin errors++; $display("FAIL health sticky: got %b expected 1", ht_fail); end
    checks++; if (obs_q.size() < 3 || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL health word_count: got %0d expected %0d (>=3)", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL health word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete();
    exp_q.delete();
    stub_const = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_back_pressure();
    test_stop_mid_word();
    test_random_ready();
    test_reset_mid();
`ifdef PRNG_HEALTH_EN
    test_health();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
